// File: rtl/lcd_fmt_pkg.sv
// Shared definitions for the result-to-LCD formatter: FSM encoding, ASCII
// constants and the fixed text shown when the result is invalid.
package lcd_fmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_CMD,
    ST_DIGITS,
    ST_DONE
  } state_t;

  localparam int          NUM_DIGITS    = 5;
  localparam logic [7:0]  ASCII_ZERO    = 8'h30;
  localparam logic [7:0]  ASCII_SPACE   = 8'h20;
  localparam logic [7:0]  LCD_SET_DDRAM = 8'h80;
  localparam logic [39:0] OVFL_STR      = 40'h4F56464C20;  // "OVFL "

  function automatic logic [7:0] ovfl_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return OVFL_STR[39:32];
      3'd1:    return OVFL_STR[31:24];
      3'd2:    return OVFL_STR[23:16];
      3'd3:    return OVFL_STR[15:8];
      default: return OVFL_STR[7:0];
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: 16-bit binary to 5 BCD digits, one bit per clock.
// bcd_done is high during the 16th iteration; bcd holds its result until the next load.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        bcd_done
);

  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [19:0] adj;
  logic [35:0] shifted;

  assign bcd      = bcd_q;
  assign bcd_done = active_q && (cnt_q == 4'd15);

  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    adj      = bcd_q;
    shifted  = '0;

    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    if (load) begin
      bin_d    = bin;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      shifted  = {adj, bin_q} << 1;
      bcd_d    = shifted[35:16];
      bin_d    = shifted[15:0];
      cnt_d    = cnt_q + 4'd1;
      if (bcd_done) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/result_lcd_formatter.sv
// Formats the 16-bit datapath result as 5 ASCII digits (or "OVFL ") and streams
// an optional DDRAM cursor command plus the digits over a valid/ready byte port.
module result_lcd_formatter
  import lcd_fmt_pkg::*;
#(
  parameter logic [6:0] LCD_ADDR    = 7'h40,
  parameter bit         CMD_EN      = 1'b1,
  parameter bit         BLANK_ZEROS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        ovf,
  output logic        busy,
  output logic        done,
  output logic [7:0]  char_data,
  output logic        char_is_cmd,
  output logic        char_valid,
  input  logic        char_ready
);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        ovf_q, ovf_d;
  logic        seen_q, seen_d;
  logic        conv_load;
  logic [19:0] bcd;
  logic        bcd_done;
  logic [3:0]  cur_digit;
  logic        is_last;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .load     (conv_load),
    .bin      (value),
    .bcd      (bcd),
    .bcd_done (bcd_done)
  );

  always_comb begin
    case (idx_q)
      3'd0:    cur_digit = bcd[19:16];
      3'd1:    cur_digit = bcd[15:12];
      3'd2:    cur_digit = bcd[11:8];
      3'd3:    cur_digit = bcd[7:4];
      default: cur_digit = bcd[3:0];
    endcase
  end

  assign is_last = (idx_q == 3'(NUM_DIGITS - 1));

  // Outputs decode straight from registered state, so char_valid never
  // depends on char_ready and drops as soon as rst clears the state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    seen_d      = seen_q;
    conv_load   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    char_valid  = 1'b0;
    char_is_cmd = 1'b0;
    char_data   = 8'h00;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          ovf_d  = ovf;
          idx_d  = '0;
          seen_d = 1'b0;
          if (ovf) begin
            state_d = CMD_EN ? ST_CMD : ST_DIGITS;
          end else begin
            conv_load = 1'b1;
            state_d   = ST_CONVERT;
          end
        end
      end

      ST_CONVERT: begin
        if (bcd_done) begin
          state_d = CMD_EN ? ST_CMD : ST_DIGITS;
        end
      end

      ST_CMD: begin
        char_valid  = 1'b1;
        char_is_cmd = 1'b1;
        char_data   = LCD_SET_DDRAM | {1'b0, LCD_ADDR};
        if (char_ready) begin
          state_d = ST_DIGITS;
        end
      end

      ST_DIGITS: begin
        char_valid = 1'b1;
        if (ovf_q) begin
          char_data = ovfl_char(idx_q);
        end else if (BLANK_ZEROS && !seen_q && (cur_digit == 4'd0) && !is_last) begin
          char_data = ASCII_SPACE;
        end else begin
          char_data = ASCII_ZERO | {4'h0, cur_digit};
        end
        if (char_ready) begin
          seen_d = seen_q | (cur_digit != 4'd0);
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      seen_q  <= seen_d;
    end
  end

endmodule

// File: tb/tb_result_lcd_formatter.sv
// Directed bench for result_lcd_formatter: instance a uses defaults, instance b
// has CMD_EN=0 and BLANK_ZEROS=0; expected bytes are queued per instance.
module tb_result_lcd_formatter;

  logic        clk, rst;
  logic        start_a, start_b, ready_a, ready_b, ovf;
  logic [15:0] value;
  logic        a_busy, a_done, a_cmd, a_valid;
  logic        b_busy, b_done, b_cmd, b_valid;
  logic [7:0]  a_data, b_data;

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  result_lcd_formatter u_a (
    .clk(clk), .rst(rst), .start(start_a), .value(value), .ovf(ovf),
    .busy(a_busy), .done(a_done), .char_data(a_data), .char_is_cmd(a_cmd),
    .char_valid(a_valid), .char_ready(ready_a)
  );

  result_lcd_formatter #(.LCD_ADDR(7'h40), .CMD_EN(1'b0), .BLANK_ZEROS(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .value(value), .ovf(ovf),
    .busy(b_busy), .done(b_done), .char_data(b_data), .char_is_cmd(b_cmd),
    .char_valid(b_valid), .char_ready(ready_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: decimal digits by division, independent of double-dabble.
  task automatic push_exp(input bit sel, input logic [15:0] v, input bit o);
    int d[5];
    int t;
    bit seen;
    logic [7:0] ov[5];
    logic [8:0] b;
    ov = '{8'h4F, 8'h56, 8'h46, 8'h4C, 8'h20};
    t = int'(v);
    seen = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      d[i] = t % 10;
      t = t / 10;
    end
    if (!sel) qa.push_back({1'b1, 8'hC0});
    for (int i = 0; i < 5; i++) begin
      if (o) b = {1'b0, ov[i]};
      else if (!sel && !seen && d[i] == 0 && i < 4) b = 9'h020;
      else b = {1'b0, 8'h30 + 8'(d[i])};
      if (d[i] != 0) seen = 1'b1;
      if (sel) qb.push_back(b);
      else qa.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    static bit stall = 1'b0;
    static logic [8:0] prev = '0;
    if (!rst) begin
      if (a_valid && ready_a) begin
        check("a_qsize", 32'(qa.size() > 0), 1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check("a_byte", {a_cmd, a_data}, e);
        end
      end
      if (stall && a_valid) check("a_stable", {a_cmd, a_data}, prev);
      stall = a_valid && !ready_a;
      prev  = {a_cmd, a_data};
    end else begin
      stall = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && b_valid && ready_b) begin
      check("b_qsize", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_byte", {b_cmd, b_data}, e);
      end
    end
  end

  // Latency counts: lat = 1 + edges after the accepting edge when valid is first seen.
  task automatic run(input bit sel, input logic [15:0] v, input bit o, input bit tog,
                     input int exp_lat, input int exp_done, input int exp_busy);
    int lat, done_at, busy_cnt, c;
    bit saw_done, cb, cv, cd;
    lat = -1; done_at = -1; busy_cnt = 0; c = 0; saw_done = 1'b0;
    push_exp(sel, v, o);
    value = v;
    ovf = o;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    value = ~v;
    ovf = !o;
    while (1) begin
      cb = sel ? b_busy : a_busy;
      cv = sel ? b_valid : a_valid;
      cd = sel ? b_done : a_done;
      if (cb) busy_cnt++;
      if (cv && lat < 0) lat = c + 1;
      if (cd) begin
        saw_done = 1'b1;
        done_at = c;
      end
      if (saw_done && !cb) break;
      if (c >= 400) break;
      if (tog) begin
        if (sel) ready_b = !ready_b; else ready_a = !ready_a;
      end
      step();
      c++;
    end
    check("timeout", 32'(saw_done), 1);
    check("first_valid", lat, exp_lat);
    if (exp_done >= 0) check("done_at", done_at, exp_done);
    if (exp_busy >= 0) check("busy_cycles", busy_cnt, exp_busy);
    check("q_left", sel ? qb.size() : qa.size(), 0);
    ready_a = 1'b1;
    ready_b = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    ovf = 1'b0; value = 16'h0;
    repeat (3) step();
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_valid", a_valid, 0);
    check("rst_is_cmd", a_cmd, 0);
    check("rst_data", a_data, 8'h00);
    check("rst_b_valid", b_valid, 0);
    rst = 1'b0;
    step();
    check("idle_busy", a_busy, 0);

    run(1'b0, 16'd0,     1'b0, 1'b0, 17, 22, 23);
    run(1'b0, 16'd65535, 1'b0, 1'b0, 17, 22, 23);
    run(1'b0, 16'd1024,  1'b0, 1'b1, 17, -1, -1);
    run(1'b0, 16'd1234,  1'b1, 1'b0, 1, 6, 7);
    run(1'b0, 16'd10009, 1'b0, 1'b0, 17, 22, 23);
    run(1'b0, 16'd9,     1'b0, 1'b1, 17, -1, -1);
    run(1'b1, 16'd100,   1'b0, 1'b0, 17, 21, 22);
    run(1'b1, 16'd4321,  1'b1, 1'b0, 1, 5, 6);
    run(1'b1, 16'd65535, 1'b0, 1'b0, 17, 21, 22);

    // Start while busy is ignored; async reset mid-emit discards the sequence.
    push_exp(1'b0, 16'd12345, 1'b0);
    value = 16'd12345; ovf = 1'b0; start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (18) step();
    value = 16'd999; start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("busy_mid", a_busy, 1);
    check("q_mid", qa.size(), 3);
    rst = 1'b1;
    #1;
    check("arst_valid", a_valid, 0);
    check("arst_busy", a_busy, 0);
    check("arst_data", a_data, 8'h00);
    qa.delete();
    step();
    step();
    rst = 1'b0;
    step();
    run(1'b0, 16'd7, 1'b0, 1'b0, 17, 22, 23);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
